uart_frame_rx: RTL and testbench

Parametrised receiver for length-prefixed frames on the UART byte stream. Accepts a start strobe, then a big-endian length field, the payload words and a terminator word. Forwards each payload word with a valid strobe and reports completion or a coded error. Sits between the UART byte receiver and the downstream FIFO/packet logic. Generalises the fixed 8-bit, 2-byte-length receiver with a valid handshake, configurable widths, a length limit, terminator checking and an inactivity timeout.

---
 rtl/uart_frame_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_frame_rx.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Receives length-prefixed frames from a UART byte stream. After a start
//   strobe it collects a big-endian length field, forwards each payload word
//   with a one-cycle valid strobe and then checks the terminator word. Frames
//   end with either a done strobe (frame_len updated) or an err strobe with a
//   coded reason. Too long a silence while busy aborts the frame.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   start      begin frame reception (sampled only while idle)
//   in_valid   in_data carries a word this cycle
//   in_data    stream word
//   out_data   forwarded payload word (registered)
//   out_valid  one-cycle strobe qualifying out_data
//   done       one-cycle strobe, frame accepted
//   err        one-cycle strobe, frame aborted
//   err_code   1 = bad terminator, 2 = length too large, 3 = timeout
//   busy       high whenever a frame is in progress
//   frame_len  payload length of the last completed frame
module uart_frame_rx #(
  parameter int                DATA_W    = 8,
  parameter int                LEN_BYTES = 2,
  parameter logic [DATA_W-1:0] TERM      = DATA_W'(8'hBB),
  parameter int unsigned       MAX_LEN   = 65535,
  parameter int                TIMEOUT   = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic                          busy,
  output logic [LEN_BYTES*DATA_W-1:0]   frame_len
);

  localparam int LEN_W  = LEN_BYTES * DATA_W;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W  = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LEN_BYTES - 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_M1 = IDLE_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0]  MAX_L      = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_TERM
  } state_t;

  state_t              state, state_next;
  logic [LEN_W-1:0]    len_acc, len_acc_next;
  logic [LEN_W-1:0]    len_shifted;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [LEN_W-1:0]    remaining, remaining_next;
  logic [IDLE_W-1:0]   idle_cnt, idle_next;
  logic [DATA_W-1:0]   out_data_next;
  logic                out_valid_next, done_next, err_next, busy_next;
  logic [1:0]          err_code_next;
  logic [LEN_W-1:0]    frame_len_next;

  // Length words arrive MSB first, so each new word shifts in at the bottom.
  // Truncating the concatenation also covers a single-word length field.
  assign len_shifted = LEN_W'({len_acc, in_data});

  // State and output registers. len_acc keeps the assembled length for the
  // whole frame so it can be published as frame_len on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_acc   <= '0;
      idx       <= '0;
      remaining <= '0;
      idle_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      busy      <= 1'b0;
      frame_len <= '0;
    end else begin
      state     <= state_next;
      len_acc   <= len_acc_next;
      idx       <= idx_next;
      remaining <= remaining_next;
      idle_cnt  <= idle_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      done      <= done_next;
      err       <= err_next;
      err_code  <= err_code_next;
      busy      <= busy_next;
      frame_len <= frame_len_next;
    end
  end

  // Next-state and next-output logic. An accepted word always beats the
  // timeout; the timeout fires on the idle cycle that would bring the
  // counter up to TIMEOUT, so gaps shorter than TIMEOUT are tolerated.
  always_comb begin
    state_next     = state;
    len_acc_next   = len_acc;
    idx_next       = idx;
    remaining_next = remaining;
    idle_next      = idle_cnt;
    out_data_next  = out_data;
    out_valid_next = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;
    err_code_next  = err_code;
    frame_len_next = frame_len;

    if (state == S_IDLE) begin
      if (start) begin
        state_next   = S_LEN;
        len_acc_next = '0;
        idx_next     = '0;
        idle_next    = '0;
      end
    end else if (in_valid) begin
      idle_next = '0;
      case (state)
        S_LEN: begin
          len_acc_next = len_shifted;
          if (idx == LAST_IDX) begin
            if (len_shifted > MAX_L) begin
              err_next      = 1'b1;
              err_code_next = 2'd2;
              state_next    = S_IDLE;
            end else if (len_shifted == '0) begin
              state_next = S_TERM;
            end else begin
              remaining_next = len_shifted;
              state_next     = S_DATA;
            end
          end else begin
            idx_next = idx + 1'b1;
          end
        end
        S_DATA: begin
          out_data_next  = in_data;
          out_valid_next = 1'b1;
          remaining_next = remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_next = S_TERM;
          end
        end
        default: begin
          state_next = S_IDLE;
          if (in_data == TERM) begin
            done_next      = 1'b1;
            frame_len_next = len_acc;
          end else begin
            err_next      = 1'b1;
            err_code_next = 2'd1;
          end
        end
      endcase
    end else if (idle_cnt == TIMEOUT_M1) begin
      err_next      = 1'b1;
      err_code_next = 2'd3;
      state_next    = S_IDLE;
    end else begin
      idle_next = idle_cnt + 1'b1;
    end

    busy_next = (state_next != S_IDLE);
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
//   Scoreboard bench for uart_frame_rx. Two instances are used: dut_a with a
//   two-word length field, MAX_LEN=4 and TIMEOUT=16, and dut_b with a
//   one-word length field. Expected output events (word, done, err) are
//   queued together with the cycle they must appear in while stimulus is
//   driven; a negedge monitor pops and compares them as the DUTs produce
//   them. Scenario tasks add their own status checks.
module tb_uart_frame_rx;

  localparam logic [1:0] K_WORD = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic        dut;
    logic [1:0]  kind;
    logic [15:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passed;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  exp_e;
  ev_t  obs_e;

  logic        a_start, a_in_valid;
  logic [7:0]  a_in_data, a_out_data;
  logic        a_out_valid, a_done, a_err, a_busy;
  logic [1:0]  a_err_code;
  logic [15:0] a_frame_len;

  logic        b_start, b_in_valid;
  logic [7:0]  b_in_data, b_out_data;
  logic        b_out_valid, b_done, b_err, b_busy;
  logic [1:0]  b_err_code;
  logic [7:0]  b_frame_len;

  uart_frame_rx #(
    .DATA_W   (8),
    .LEN_BYTES(2),
    .TERM     (8'hBB),
    .MAX_LEN  (4),
    .TIMEOUT  (16)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (a_start),
    .in_valid (a_in_valid),
    .in_data  (a_in_data),
    .out_data (a_out_data),
    .out_valid(a_out_valid),
    .done     (a_done),
    .err      (a_err),
    .err_code (a_err_code),
    .busy     (a_busy),
    .frame_len(a_frame_len)
  );

  uart_frame_rx #(
    .DATA_W   (8),
    .LEN_BYTES(1)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (b_start),
    .in_valid (b_in_valid),
    .in_data  (b_in_data),
    .out_data (b_out_data),
    .out_valid(b_out_valid),
    .done     (b_done),
    .err      (b_err),
    .err_code (b_err_code),
    .busy     (b_busy),
    .frame_len(b_frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every output event seen this cycle and match it, in order,
  // against the front of the expectation queue.
  always @(negedge clk) begin
    obs_q = {};
    if (a_out_valid) obs_q.push_back({1'b0, K_WORD, 8'h00, a_out_data, 32'(cyc)});
    if (a_done)      obs_q.push_back({1'b0, K_DONE, a_frame_len, 32'(cyc)});
    if (a_err)       obs_q.push_back({1'b0, K_ERR, 14'd0, a_err_code, 32'(cyc)});
    if (b_out_valid) obs_q.push_back({1'b1, K_WORD, 8'h00, b_out_data, 32'(cyc)});
    if (b_done)      obs_q.push_back({1'b1, K_DONE, 8'h00, b_frame_len, 32'(cyc)});
    if (b_err)       obs_q.push_back({1'b1, K_ERR, 14'd0, b_err_code, 32'(cyc)});
    while (obs_q.size() > 0) begin
      obs_e = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_event: got dut=%0d kind=%0d data=%h cyc=%0d, required none",
                 obs_e.dut, obs_e.kind, obs_e.data, obs_e.cyc);
      end else begin
        exp_e = exp_q.pop_front();
        if (obs_e !== exp_e)
          $display("[TB] FAIL scoreboard: got dut=%0d kind=%0d data=%h cyc=%0d, required dut=%0d kind=%0d data=%h cyc=%0d",
                   obs_e.dut, obs_e.kind, obs_e.data, obs_e.cyc,
                   exp_e.dut, exp_e.kind, exp_e.data, exp_e.cyc);
        else
          passed++;
      end
    end
  end

  // Queue an expected event 'lat' cycles after the current one.
  task automatic expect_ev(input logic dut, input logic [1:0] kind,
                           input logic [15:0] data, input int lat);
    exp_q.push_back({dut, kind, data, 32'(cyc + lat)});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_word(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    idle(1);
    a_in_valid = 1'b0;
    a_in_data  = 8'h00;
  endtask

  task automatic a_go();
    a_start = 1'b1;
    idle(1);
    a_start = 1'b0;
  endtask

  task automatic b_word(input logic [7:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    idle(1);
    b_in_valid = 1'b0;
    b_in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if ({a_out_data, a_out_valid, a_done, a_err, a_err_code, a_busy, a_frame_len} !== 30'd0)
      $display("[TB] FAIL reset_a: got %h, required 0",
               {a_out_data, a_out_valid, a_done, a_err, a_err_code, a_busy, a_frame_len});
    else passed++;
    checks++;
    if ({b_out_data, b_out_valid, b_done, b_err, b_err_code, b_busy, b_frame_len} !== 22'd0)
      $display("[TB] FAIL reset_b: got %h, required 0",
               {b_out_data, b_out_valid, b_done, b_err, b_err_code, b_busy, b_frame_len});
    else passed++;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    a_go();
    checks++;
    if (a_busy !== 1'b1) $display("[TB] FAIL busy_after_start: got %b, required 1", a_busy);
    else passed++;
    a_word(8'h00);
    a_word(8'h03);
    expect_ev(1'b0, K_WORD, 16'h0011, 1); a_word(8'h11);
    expect_ev(1'b0, K_WORD, 16'h0022, 1); a_word(8'h22);
    expect_ev(1'b0, K_WORD, 16'h0033, 1); a_word(8'h33);
    expect_ev(1'b0, K_DONE, 16'd3, 1);    a_word(8'hBB);
    checks++;
    if (a_busy !== 1'b0) $display("[TB] FAIL busy_on_done: got %b, required 0", a_busy);
    else passed++;
    idle(2);
    checks++;
    if ({a_frame_len, a_err_code} !== {16'd3, 2'd0})
      $display("[TB] FAIL basic_status: got len=%0d code=%0d, required len=3 code=0", a_frame_len, a_err_code);
    else passed++;
  endtask

  task automatic test_zero_len();
    a_go();
    a_word(8'h00);
    a_word(8'h00);
    expect_ev(1'b0, K_DONE, 16'd0, 1); a_word(8'hBB);
    idle(2);
    checks++;
    if (a_frame_len !== 16'd0) $display("[TB] FAIL zero_len: got %0d, required 0", a_frame_len);
    else passed++;
    a_go();
    idle(3);
    a_word(8'h00); idle(3);
    a_word(8'h01); idle(3);
    expect_ev(1'b0, K_WORD, 16'h007E, 1); a_word(8'h7E); idle(3);
    expect_ev(1'b0, K_DONE, 16'd1, 1);    a_word(8'hBB);
    idle(2);
    checks++;
    if (a_frame_len !== 16'd1) $display("[TB] FAIL gap_frame_len: got %0d, required 1", a_frame_len);
    else passed++;
  endtask

  task automatic test_bad_term();
    a_go();
    a_word(8'h00);
    a_word(8'h01);
    expect_ev(1'b0, K_WORD, 16'h00AA, 1); a_word(8'hAA);
    expect_ev(1'b0, K_ERR, 16'd1, 1);     a_word(8'hCC);
    idle(2);
    checks++;
    if ({a_frame_len, a_err_code, a_busy} !== {16'd1, 2'd1, 1'b0})
      $display("[TB] FAIL bad_term_status: got len=%0d code=%0d busy=%b, required len=1 code=1 busy=0",
               a_frame_len, a_err_code, a_busy);
    else passed++;
  endtask

  task automatic test_timeout();
    a_go();
    a_word(8'h00);
    a_word(8'h02);
    // 16 idle cycles follow the 55 word; the 16th one raises err.
    expect_ev(1'b0, K_WORD, 16'h0055, 1);
    expect_ev(1'b0, K_ERR, 16'd3, 17);
    a_word(8'h55);
    idle(15);
    checks++;
    if (a_busy !== 1'b1) $display("[TB] FAIL busy_before_timeout: got %b, required 1", a_busy);
    else passed++;
    idle(1);
    checks++;
    if ({a_busy, a_err_code} !== {1'b0, 2'd3})
      $display("[TB] FAIL timeout_status: got busy=%b code=%0d, required busy=0 code=3", a_busy, a_err_code);
    else passed++;
    idle(3);
    a_go();
    a_word(8'h00);
    a_word(8'h02);
    expect_ev(1'b0, K_WORD, 16'h0055, 1); a_word(8'h55);
    idle(15);
    expect_ev(1'b0, K_WORD, 16'h0066, 1); a_word(8'h66);
    expect_ev(1'b0, K_DONE, 16'd2, 1);    a_word(8'hBB);
    idle(2);
  endtask

  task automatic test_max_len();
    a_go();
    a_word(8'h00);
    expect_ev(1'b0, K_ERR, 16'd2, 1); a_word(8'h05);
    idle(2);
    checks++;
    if ({a_busy, a_err_code} !== {1'b0, 2'd2})
      $display("[TB] FAIL max_len_status: got busy=%b code=%0d, required busy=0 code=2", a_busy, a_err_code);
    else passed++;
    a_go();
    a_word(8'h00);
    a_word(8'h04);
    for (int i = 0; i < 4; i++) begin
      expect_ev(1'b0, K_WORD, 16'(8'hC0 + i), 1);
      a_word(8'(8'hC0 + i));
    end
    expect_ev(1'b0, K_DONE, 16'd4, 1); a_word(8'hBB);
    idle(2);
    checks++;
    if (a_frame_len !== 16'd4) $display("[TB] FAIL max_len_frame: got %0d, required 4", a_frame_len);
    else passed++;
  endtask

  task automatic test_one_byte_len();
    b_start = 1'b1;
    idle(1);
    b_start = 1'b0;
    b_word(8'h02);
    expect_ev(1'b1, K_WORD, 16'h00A1, 1); b_word(8'hA1);
    expect_ev(1'b1, K_WORD, 16'h00A2, 1); b_word(8'hA2);
    expect_ev(1'b1, K_DONE, 16'd2, 1);    b_word(8'hBB);
    idle(2);
    checks++;
    if ({b_frame_len, b_busy} !== {8'd2, 1'b0})
      $display("[TB] FAIL one_byte_len: got len=%0d busy=%b, required len=2 busy=0", b_frame_len, b_busy);
    else passed++;
  endtask

  task automatic test_mid_reset();
    a_go();
    a_word(8'h00);
    a_word(8'h03);
    expect_ev(1'b0, K_WORD, 16'h0011, 1); a_word(8'h11);
    expect_ev(1'b0, K_WORD, 16'h0022, 1); a_word(8'h22);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if ({a_out_data, a_out_valid, a_done, a_err, a_err_code, a_busy, a_frame_len} !== 30'd0)
      $display("[TB] FAIL mid_reset: got %h, required 0",
               {a_out_data, a_out_valid, a_done, a_err, a_err_code, a_busy, a_frame_len});
    else passed++;
    // Rest of the abandoned frame lands on an idle receiver and is ignored.
    a_word(8'h33);
    a_word(8'hBB);
    idle(2);
  endtask

  task automatic test_back_to_back();
    a_go();
    a_word(8'h00);
    a_word(8'h02);
    a_start = 1'b1;
    expect_ev(1'b0, K_WORD, 16'h0044, 1); a_word(8'h44);
    a_start = 1'b0;
    a_go();
    expect_ev(1'b0, K_WORD, 16'h0045, 1); a_word(8'h45);
    expect_ev(1'b0, K_DONE, 16'd2, 1);    a_word(8'hBB);
    // First idle cycle: start together with a word that must be ignored.
    a_start = 1'b1;
    a_word(8'h09);
    a_start = 1'b0;
    a_word(8'h00);
    a_word(8'h00);
    expect_ev(1'b0, K_DONE, 16'd0, 1); a_word(8'hBB);
    idle(2);
    checks++;
    if ({a_busy, a_frame_len} !== {1'b0, 16'd0})
      $display("[TB] FAIL back_to_back: got busy=%b len=%0d, required busy=0 len=0", a_busy, a_frame_len);
    else passed++;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc = 0; checks = 0; passed = 0;
    rst = 1'b1;
    a_start = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_bad_term();
    test_timeout();
    test_max_len();
    test_one_byte_len();
    test_mid_reset();
    test_back_to_back();
    idle(3);
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL missing_events: got %0d pending, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
